// File: rtl/ts_pkg.sv
// Shared constants and types for the TS continuity-counter monitor.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam int unsigned TS_PKT_LEN   = 188;
    localparam logic [7:0]  TS_LAST_IDX  = 8'(TS_PKT_LEN - 1);
    localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;

    // adaptation_field_control encodings; bit0 = payload present, bit1 = AF present
    localparam logic [1:0] AFC_RESERVED   = 2'b00;
    localparam logic [1:0] AFC_PAYLOAD    = 2'b01;
    localparam logic [1:0] AFC_AF_ONLY    = 2'b10;
    localparam logic [1:0] AFC_AF_PAYLOAD = 2'b11;

    typedef struct packed {
        logic        tei;
        logic [12:0] pid;
        logic [1:0]  afc;
        logic [3:0]  cc;
        logic        disc;
    } ts_hdr_t;

    typedef struct packed {
        logic        vld;
        logic [12:0] pid;
        logic [3:0]  cc;
        logic        dup;
    } pid_slot_t;

    typedef enum logic [1:0] {
        StSync,
        StHdr,
        StAf,
        StPayload
    } ts_state_e;

    function automatic logic afc_has_payload(input logic [1:0] afc);
        return afc[0];
    endfunction

endpackage

// File: rtl/ts_pid_table.sv
// Fully associative PID -> last-CC table with lowest-free-slot allocation.
// Optional macro TS_CC_DUP_EN: tolerate one duplicate payload packet per PID.
module ts_pid_table
    import ts_pkg::*;
#(
    parameter int unsigned PID_SLOTS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup,
    input  logic [12:0] pid,
    input  logic [3:0]  cc,
    input  logic [1:0]  afc,
    input  logic        disc,
    output logic        cc_err,
    output logic [3:0]  exp_cc,
    output logic        table_full
);

    localparam int unsigned IDX_W = (PID_SLOTS > 1) ? $clog2(PID_SLOTS) : 1;

    pid_slot_t            slots_q [PID_SLOTS];
    logic                 full_q;
    logic                 hit;
    logic                 free_any;
    logic [IDX_W-1:0]     hit_idx;
    logic [IDX_W-1:0]     free_idx;
    pid_slot_t            hit_slot;
    logic                 dup_ok;

    // Associative match and lowest free slot (descending scan, last write wins).
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = int'(PID_SLOTS) - 1; i >= 0; i--) begin
            if (slots_q[i].vld && (slots_q[i].pid == pid)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!slots_q[i].vld) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Expected CC and error decision for the packet under evaluation.
    always_comb begin
        hit_slot = slots_q[hit_idx];
        exp_cc   = afc_has_payload(afc) ? hit_slot.cc + 4'd1 : hit_slot.cc;
`ifdef TS_CC_DUP_EN
        dup_ok   = afc_has_payload(afc) && (cc == hit_slot.cc) && !hit_slot.dup;
`else
        dup_ok   = 1'b0;
`endif
        cc_err   = lookup && hit && !disc && (cc != exp_cc) && !dup_ok;
    end

    // Table update: refresh CC on hit, allocate on miss, flag overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(PID_SLOTS); i++) begin
                slots_q[i] <= '0;
            end
            full_q <= 1'b0;
        end else if (lookup) begin
            if (hit) begin
                slots_q[hit_idx].cc <= cc;
`ifdef TS_CC_DUP_EN
                slots_q[hit_idx].dup <= dup_ok && !disc;
`endif
            end else if (free_any) begin
                slots_q[free_idx] <= '{vld: 1'b1, pid: pid, cc: cc, dup: 1'b0};
            end else begin
                full_q <= 1'b1;
            end
        end
    end

    assign table_full = full_q;

endmodule

// File: rtl/ts_cc_monitor.sv
// Per-channel TS continuity-counter monitor: packet framer, header parser,
// one-cycle evaluation stage and saturating QoS counters.
// Optional macro TS_CC_DUP_EN (handled in ts_pid_table): allow one duplicate packet.
module ts_cc_monitor
    import ts_pkg::*;
#(
    parameter int unsigned PID_SLOTS = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [7:0]       ts_byte,
    output logic             pkt_done,
    output logic             cc_err,
    output logic [12:0]      err_pid,
    output logic [3:0]       err_exp,
    output logic [3:0]       err_got,
    output logic             sync_err,
    output logic [CNT_W-1:0] cc_err_cnt,
    output logic [CNT_W-1:0] tei_cnt,
    output logic [CNT_W-1:0] sync_err_cnt,
    output logic             table_full
);

    ts_state_e        state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    ts_hdr_t          hdr_q, hdr_d;
    logic [7:0]       af_len_q, af_len_d;
    logic             eval_vld_q, eval_vld_d;
    ts_hdr_t          eval_q, eval_d;
    logic             sync_err_q, sync_err_d;
    logic [12:0]      err_pid_q;
    logic [3:0]       err_exp_q, err_got_q;
    logic [CNT_W-1:0] cc_err_cnt_q, tei_cnt_q, sync_err_cnt_q;
    logic             lookup;
    logic             tbl_err;
    logic [3:0]       tbl_exp;

    // Framer FSM: byte index, header capture and hand-off to evaluation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hdr_d      = hdr_q;
        af_len_d   = af_len_q;
        eval_vld_d = 1'b0;
        eval_d     = eval_q;
        sync_err_d = 1'b0;
        if (valid) begin
            unique case (state_q)
                StSync: begin
                    if (ts_byte == TS_SYNC_BYTE) begin
                        state_d  = StHdr;
                        idx_d    = 8'd1;
                        hdr_d    = '0;
                        af_len_d = '0;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
                StHdr: begin
                    idx_d = idx_q + 8'd1;
                    case (idx_q)
                        8'd1: begin
                            hdr_d.tei       = ts_byte[7];
                            hdr_d.pid[12:8] = ts_byte[4:0];
                        end
                        8'd2: hdr_d.pid[7:0] = ts_byte;
                        default: begin
                            hdr_d.afc = ts_byte[5:4];
                            hdr_d.cc  = ts_byte[3:0];
                            state_d   = ts_byte[5] ? StAf : StPayload;
                        end
                    endcase
                end
                StAf: begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'd4) begin
                        af_len_d = ts_byte;
                    end else begin
                        // An empty adaptation field carries no flags byte.
                        if (af_len_q != 8'd0) begin
                            hdr_d.disc = ts_byte[7];
                        end
                        state_d = StPayload;
                    end
                end
                StPayload: begin
                    if (idx_q == TS_LAST_IDX) begin
                        idx_d      = 8'd0;
                        state_d    = StSync;
                        eval_vld_d = 1'b1;
                        eval_d     = hdr_q;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                default: state_d = StSync;
            endcase
        end
    end

    // Framer and evaluation registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StSync;
            idx_q      <= '0;
            hdr_q      <= '0;
            af_len_q   <= '0;
            eval_vld_q <= 1'b0;
            eval_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hdr_q      <= hdr_d;
            af_len_q   <= af_len_d;
            eval_vld_q <= eval_vld_d;
            eval_q     <= eval_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Null PID and TEI packets never touch the table.
    assign lookup = eval_vld_q && !eval_q.tei && (eval_q.pid != TS_NULL_PID);

    ts_pid_table #(
        .PID_SLOTS (PID_SLOTS)
    ) u_pid_table (
        .clk        (clk),
        .rst        (rst),
        .lookup     (lookup),
        .pid        (eval_q.pid),
        .cc         (eval_q.cc),
        .afc        (eval_q.afc),
        .disc       (eval_q.disc),
        .cc_err     (tbl_err),
        .exp_cc     (tbl_exp),
        .table_full (table_full)
    );

    // Last-error capture and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pid_q      <= '0;
            err_exp_q      <= '0;
            err_got_q      <= '0;
            cc_err_cnt_q   <= '0;
            tei_cnt_q      <= '0;
            sync_err_cnt_q <= '0;
        end else begin
            if (tbl_err) begin
                err_pid_q <= eval_q.pid;
                err_exp_q <= tbl_exp;
                err_got_q <= eval_q.cc;
                if (cc_err_cnt_q != '1) cc_err_cnt_q <= cc_err_cnt_q + CNT_W'(1);
            end
            if (eval_vld_q && eval_q.tei && (tei_cnt_q != '1)) begin
                tei_cnt_q <= tei_cnt_q + CNT_W'(1);
            end
            if (sync_err_d && (sync_err_cnt_q != '1)) begin
                sync_err_cnt_q <= sync_err_cnt_q + CNT_W'(1);
            end
        end
    end

    // Error details are visible in the same cycle as the cc_err pulse.
    assign pkt_done     = eval_vld_q;
    assign cc_err       = tbl_err;
    assign err_pid      = tbl_err ? eval_q.pid : err_pid_q;
    assign err_exp      = tbl_err ? tbl_exp    : err_exp_q;
    assign err_got      = tbl_err ? eval_q.cc  : err_got_q;
    assign sync_err     = sync_err_q;
    assign cc_err_cnt   = cc_err_cnt_q;
    assign tei_cnt      = tei_cnt_q;
    assign sync_err_cnt = sync_err_cnt_q;

endmodule
